// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   rx_state_e : receiver FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   PRESC_8/16/32 : the legal oversampling ratios
//   par_bit()  : parity bit for a byte; typ = 1 odd, typ = 0 even
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic par_bit(input logic [7:0] data, input logic typ);
    return typ ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// ---------------------------------------------------------------------------
// uart_rx_data_sampling
// Three-sample majority voter for one oversampled bit.
//   clk, rst_n   : receiver clock, asynchronous active-low reset
//   rx_s         : synchronized serial line
//   edge_cnt     : position inside the current bit, 0..prescale-1
//   prescale     : effective oversampling ratio of the current frame
//   sampled_bit  : 2-of-3 majority of the samples at P/2-1, P/2, P/2+1
//   sample_done  : high while edge_cnt = P/2+1, the cycle the vote is valid
// ---------------------------------------------------------------------------
module uart_rx_data_sampling #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_s,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] prescale,
  output logic               sampled_bit,
  output logic               sample_done
);

  logic [PRESC_W-1:0] half;
  logic               s0;
  logic               s1;

  assign half = prescale >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (edge_cnt == half - PRESC_W'(1)) s0 <= rx_s;
      if (edge_cnt == half)               s1 <= rx_s;
    end
  end

  // The third sample is the live line value, so the vote is ready at P/2+1.
  assign sampled_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign sample_done = (edge_cnt == half + PRESC_W'(1));

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start 0, 8 data bits LSB first, optional
// parity, one stop bit.
//   CLK, RST_n   : receiver clock (PRESCALE x bit rate), async active-low reset
//   RX_IN        : asynchronous serial input, idle high
//   PRESCALE     : oversampling ratio 8/16/32 (anything else acts as 8)
//   PAR_EN       : parity bit present
//   PAR_TYP      : 1 odd, 0 even parity
//   P_DATA       : last correctly received byte
//   DATA_VALID   : one-cycle strobe, P_DATA updated this cycle
//   PAR_ERR      : one-cycle strobe, parity mismatch in the frame just ended
//   STP_ERR      : one-cycle strobe, stop bit sampled 0
//   fsm_state    : current receiver state, for observation only
// Output protocol: the strobes carry no back-pressure; a consumer must take
// P_DATA in the cycle DATA_VALID is high. All strobes rise on the edge after
// the stop-bit decision and last exactly one cycle.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output rx_state_e             fsm_state
);

  logic                  rx_q1;
  logic                  rx_s;
  rx_state_e             state;
  rx_state_e             next_state;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [PRESC_W-1:0]    presc_r;
  logic [PRESC_W-1:0]    presc_eff;
  logic [2:0]            bit_cnt;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_err_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  wrap;
  logic                  valid_d;
  logic                  par_err_d;
  logic                  stp_err_d;

  assign presc_eff = (PRESCALE == PRESC_W'(PRESC_16) || PRESCALE == PRESC_W'(PRESC_32))
                     ? PRESCALE : PRESC_W'(PRESC_8);
  assign wrap      = (edge_cnt == presc_r - PRESC_W'(1));
  assign fsm_state = state;

  uart_rx_data_sampling #(.PRESC_W(PRESC_W)) u_sampling (
    .clk         (CLK),
    .rst_n       (RST_n),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .prescale    (presc_r),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (!rx_s) next_state = START;
      START: begin
        // A high vote mid start bit was a glitch, not a frame.
        if (sample_done && sampled_bit) next_state = IDLE;
        else if (wrap)                  next_state = DATA;
      end
      DATA:   if (wrap && bit_cnt == 3'(DATA_WIDTH - 1))
                next_state = par_en_r ? PARITY : STOP;
      PARITY: if (wrap) next_state = STOP;
      // Leaving mid stop bit lets a back-to-back start edge be caught.
      STOP:   if (sample_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode at the stop decision; registered below.
  always_comb begin
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    if (state == STOP && sample_done) begin
      valid_d   = sampled_bit && !par_err_r;
      par_err_d = par_err_r;
      stp_err_d = !sampled_bit;
    end
  end

  // Synchronizer, counters, deserializer, frame config and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_q1      <= 1'b1;
      rx_s       <= 1'b1;
      edge_cnt   <= '0;
      presc_r    <= PRESC_W'(PRESC_8);
      bit_cnt    <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_err_r  <= 1'b0;
      shift_r    <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      rx_q1 <= RX_IN;
      rx_s  <= rx_q1;

      // The IDLE cycle that first sees the low line is edge 0 of the start
      // bit, so counting resumes at 1 in START.
      if (next_state == IDLE)  edge_cnt <= '0;
      else if (state == IDLE)  edge_cnt <= PRESC_W'(1);
      else if (wrap)           edge_cnt <= '0;
      else                     edge_cnt <= edge_cnt + PRESC_W'(1);

      if (state == IDLE && !rx_s) begin
        presc_r   <= presc_eff;
        par_en_r  <= PAR_EN;
        par_typ_r <= PAR_TYP;
      end

      if (state == START)             bit_cnt <= '0;
      else if (state == DATA && wrap) bit_cnt <= bit_cnt + 3'd1;

      if (state == DATA && sample_done)
        shift_r <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};

      if (state == START)
        par_err_r <= 1'b0;
      else if (state == PARITY && sample_done)
        par_err_r <= (sampled_bit != par_bit(shift_r, par_typ_r));

      DATA_VALID <= valid_d;
      PAR_ERR    <= par_err_d;
      STP_ERR    <= stp_err_d;
      if (valid_d) P_DATA <= shift_r;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Drives UART frames bit by bit on RX_IN and predicts, per frame, the strobe
// cycle, strobe pattern and P_DATA from the frame contents alone.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W = 43;  // {cycle[31:0], p_data[7:0], valid, par_err, stp_err}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [5:0]  prescale = 6'd8;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        par_err;
  logic        stp_err;
  rx_state_e   fsm_state;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [7:0]   last_good = 8'h00;

  uart_rx dut (
    .CLK        (clk),
    .RST_n      (rst_n),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err),
    .fsm_state  (fsm_state)
  );

  // ---- clock / reset / cycle counter ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---- checker ----
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- reference model helpers ----
  function automatic int eff_p(input int cfg);
    if (cfg == 16 || cfg == 32) return cfg;
    return 8;
  endfunction

  task automatic drive_bit(input logic b, input int p);
    repeat (p) begin
      @(posedge clk);
      #1;
      rx_in = b;
    end
  endtask

  // One full frame. flip inverts the correct parity bit, bad_stop sends 0 as
  // the stop bit, gap is the number of idle bit times after the stop bit.
  task automatic send_frame(input logic [7:0] d, input int cfg, input logic pen,
                            input logic ptyp, input logic flip, input logic bad_stop,
                            input int gap);
    int          p;
    int          ones;
    int unsigned ks;
    logic        pbit;
    logic        e_pe;
    logic        e_se;
    logic        e_v;
    p        = eff_p(cfg);
    prescale = cfg[5:0];
    par_en   = pen;
    par_typ  = ptyp;
    drive_bit(1'b0, p);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], p);
      ones += int'(d[i]);
    end
    e_pe = 1'b0;
    if (pen) begin
      // Parity bit that makes the total count of ones odd (odd) or even (even).
      pbit = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (flip) begin
        pbit = ~pbit;
        e_pe = 1'b1;
      end
      drive_bit(pbit, p);
    end
    @(posedge clk);
    #1;
    rx_in = ~bad_stop;
    ks    = cyc;
    e_se  = bad_stop;
    e_v   = !e_pe && !e_se;
    if (e_v) last_good = d;
    // Strobe lands 2 (sync) + P/2 (to mid bit) + 2 (vote and register) after
    // the stop bit starts on the line.
    exp_q.push_back({32'(ks + 32'(p / 2) + 32'd4), last_good, e_v, e_pe, e_se});
    drive_bit(~bad_stop, p - 1);
    drive_bit(1'b1, gap * p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_data"}, 64'(p_data), 64'h0);
    check({tag, "_strobes"}, 64'({data_valid, par_err, stp_err}), 64'h0);
    check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        if (cyc > mon_e[42:11]) begin
          check("missed_strobe", 64'(cyc), 64'(mon_e[42:11]));
          void'(exp_q.pop_front());
        end
      end
      if (data_valid || par_err || stp_err) begin
        if (exp_q.size() == 0) begin
          check("spurious_strobe", 64'({data_valid, par_err, stp_err}), 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(mon_e[42:11]));
          check("strobes", 64'({data_valid, par_err, stp_err}), 64'(mon_e[2:0]));
          check("p_data", 64'(p_data), 64'(mon_e[10:3]));
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int cfgs[8];
    int   cfg;
    logic pen;
    logic flip;
    logic bad;
    int   gap;
    logic [7:0] d12;
    cfgs = '{8, 16, 32, 8, 16, 32, 12, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 20);

    // good frame, odd parity, P=8
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    // wrong even parity, P=16: P_DATA must keep 0xA5
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    // bad stop then clean repeat
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // 3-cycle glitch must not start a frame
    prescale = 6'd16;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20 * 16);
    @(negedge clk);
    check("glitch_state", 64'(fsm_state), 64'(IDLE));
    check("glitch_pending", 64'(exp_q.size()), 64'h0);

    // back-to-back frames at P=32
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // reset during data bit 3 of 0x12
    prescale = 6'd8;
    par_en   = 1'b0;
    d12      = 8'h12;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(d12[i], 8);
    drive_bit(d12[3], 2);
    rst_n = 1'b0;
    rx_in = 1'b1;
    last_good = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 12 * 8);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // randomized frames, including illegal prescale values
    for (int n = 0; n < 40; n++) begin
      cfg  = cfgs[$urandom_range(0, 7)];
      pen  = 1'($urandom_range(0, 1));
      flip = pen && ($urandom_range(0, 5) == 0);
      bad  = ($urandom_range(0, 7) == 0);
      gap  = bad ? 2 : int'($urandom_range(0, 2));
      send_frame(8'($urandom_range(0, 255)), cfg, pen, 1'($urandom_range(0, 1)),
                 flip, bad, gap);
    end

    rx_in = 1'b1;
    drive_bit(1'b1, 64);
    check("final_pending", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
